// File: rtl/sd_switch_pkg.sv
// sd_switch_pkg
//   Shared types and default constants for the SD SPI bus switch.
//   state_t : arbitration state (ACTIVE / DRAIN / GUARD)
//   *_DEF   : default values for the switch parameters
package sd_switch_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,  // bus routed to the selected card
        DRAIN  = 2'd1,  // switch requested, waiting for the master to deselect
        GUARD  = 2'd2   // both cards isolated, counting idle cycles
    } state_t;

    localparam int GUARD_CYCLES_DEF  = 16;
    localparam int DRAIN_TIMEOUT_DEF = 4194304;
    localparam int ACT_HOLD_DEF      = 1000000;

endpackage

// File: rtl/sd_act_timer.sv
// sd_act_timer
//   SD activity detector: any change on MOSI or MISO restarts a saturating
//   hold counter; act stays high until ACT_HOLD quiet cycles have elapsed.
//   Ports:
//     clk_sys, reset_n : clock, async active-low reset
//     mosi, miso       : data lines observed at the master side
//     act              : activity flag
module sd_act_timer
    import sd_switch_pkg::*;
#(
    parameter int ACT_HOLD = ACT_HOLD_DEF
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic mosi,
    input  logic miso,
    output logic act
);

    localparam int CW = $clog2(ACT_HOLD) + 1;

    logic [CW-1:0] act_cnt;
    logic          mosi_q;
    logic          miso_q;

    // The counter resets to 0, so the flag is deliberately high for
    // ACT_HOLD cycles after reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            act_cnt <= '0;
            mosi_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            mosi_q <= mosi;
            miso_q <= miso;
            if ((mosi != mosi_q) || (miso != miso_q))
                act_cnt <= '0;
            else if (act_cnt != CW'(ACT_HOLD))
                act_cnt <= act_cnt + 1'b1;
        end
    end

    assign act = (act_cnt < CW'(ACT_HOLD));

endmodule

// File: rtl/sd_spi_switch.sv
// sd_spi_switch
//   Routes the single MMC SPI master to either the physical SD slot (p_*) or
//   the virtual HPS-backed card (v_*). The target is only changed after the
//   master has deselected (m_cs_n high) for GUARD_CYCLES consecutive cycles,
//   so a mount never splits an SPI transaction.
//   Optional macro SD_SWITCH_FORCE_EN: force the switch after DRAIN_TIMEOUT
//   cycles of waiting for m_cs_n, and flag it on 'forced'.
//   Ports:
//     clk_sys, reset_n          : clock, async active-low reset
//     img_mounted, img_present  : mount pulse and new image presence
//     m_sck/m_mosi/m_cs_n/m_miso: master side
//     p_*                       : physical SD slot
//     v_*                       : virtual SD card
//     vsd_sel                   : 1 = virtual card owns the bus
//     busy                      : switch pending
//     forced                    : last switch was forced by timeout
//     led_vsd, led_phys         : activity per selected target
module sd_spi_switch
    import sd_switch_pkg::*;
#(
    parameter int GUARD_CYCLES  = GUARD_CYCLES_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    parameter int ACT_HOLD      = ACT_HOLD_DEF
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic img_mounted,
    input  logic img_present,
    input  logic m_sck,
    input  logic m_mosi,
    input  logic m_cs_n,
    output logic m_miso,
    output logic p_sck,
    output logic p_mosi,
    output logic p_cs_n,
    input  logic p_miso,
    output logic v_sck,
    output logic v_mosi,
    output logic v_cs_n,
    input  logic v_miso,
    output logic vsd_sel,
    output logic busy,
    output logic forced,
    output logic led_vsd,
    output logic led_phys
);

    localparam int GW = $clog2(GUARD_CYCLES) + 1;

    if (GUARD_CYCLES < 1 || DRAIN_TIMEOUT < 1 || ACT_HOLD < 1) begin : g_bad_param
        $error("sd_spi_switch: GUARD_CYCLES, DRAIN_TIMEOUT and ACT_HOLD must be >= 1");
    end

    state_t        state;
    state_t        state_nxt;
    logic          req_sel;
    logic [GW-1:0] guard_cnt;
    logic          guard_start;
    logic          do_switch;
    logic          force_mode;   // current switch attempt ignores m_cs_n
    logic          act;

`ifdef SD_SWITCH_FORCE_EN
    localparam int DW = $clog2(DRAIN_TIMEOUT) + 1;
    logic [DW-1:0] drain_cnt;
    logic          force_start;
    logic          forced_q;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= ACTIVE;
        else          state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        guard_start = 1'b0;
        do_switch   = 1'b0;
`ifdef SD_SWITCH_FORCE_EN
        force_start = 1'b0;
`endif
        case (state)
            ACTIVE: if (req_sel != vsd_sel) state_nxt = DRAIN;
            DRAIN: begin
                if (req_sel == vsd_sel) begin
                    state_nxt = ACTIVE;            // re-mount of the current target
                end else if (m_cs_n) begin
                    state_nxt   = GUARD;
                    guard_start = 1'b1;
                end
`ifdef SD_SWITCH_FORCE_EN
                else if (drain_cnt == DW'(DRAIN_TIMEOUT - 1)) begin
                    state_nxt   = GUARD;
                    guard_start = 1'b1;
                    force_start = 1'b1;
                end
`endif
            end
            GUARD: begin
                if (req_sel == vsd_sel) begin
                    state_nxt = ACTIVE;
                end else if (!m_cs_n && !force_mode) begin
                    state_nxt = DRAIN;             // master resumed on the old target
                end else if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
                    state_nxt = ACTIVE;
                    do_switch = 1'b1;
                end
            end
            default: state_nxt = ACTIVE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req_sel   <= 1'b0;
            vsd_sel   <= 1'b0;
            guard_cnt <= '0;
        end else begin
            if (img_mounted) req_sel <= img_present;
            // On a coincident mount, vsd_sel takes the old req_sel; ACTIVE
            // evaluates the new request on the following cycle.
            if (do_switch)   vsd_sel <= req_sel;
            if (guard_start)
                guard_cnt <= '0;
            else if (state == GUARD && (m_cs_n || force_mode) &&
                     guard_cnt != GW'(GUARD_CYCLES - 1))
                guard_cnt <= guard_cnt + 1'b1;
        end
    end

`ifdef SD_SWITCH_FORCE_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt  <= '0;
            force_mode <= 1'b0;
            forced_q   <= 1'b0;
        end else begin
            // Held at zero outside DRAIN, so it starts from zero on each entry.
            if (state != DRAIN)
                drain_cnt <= '0;
            else if (drain_cnt != DW'(DRAIN_TIMEOUT))
                drain_cnt <= drain_cnt + 1'b1;
            if (force_start)
                force_mode <= 1'b1;
            else if (state_nxt != GUARD)
                force_mode <= 1'b0;
            // A normal switch clears the sticky flag, a forced one sets it.
            if (do_switch) forced_q <= force_mode;
        end
    end
    assign forced = forced_q;
`else
    assign force_mode = 1'b0;
    assign forced     = 1'b0;
`endif

    // ---------------- routing (output logic) ----------------
    // In GUARD both cards are isolated, except that a non-forced GUARD hands
    // the bus straight back to the old target the moment m_cs_n falls.
    logic route_en;
    assign route_en = (state != GUARD) || (!m_cs_n && !force_mode);

    always_comb begin
        p_sck  = 1'b0;
        p_mosi = 1'b0;
        p_cs_n = 1'b1;
        v_sck  = 1'b0;
        v_mosi = 1'b0;
        v_cs_n = 1'b1;
        m_miso = 1'b1;
        if (route_en) begin
            if (vsd_sel) begin
                v_sck  = m_sck;
                v_mosi = m_mosi;
                v_cs_n = m_cs_n;
                m_miso = v_miso;
            end else begin
                p_sck  = m_sck;
                p_mosi = m_mosi;
                p_cs_n = m_cs_n;
                m_miso = p_miso;
            end
        end
    end

    assign busy = (state != ACTIVE);

    // ---------------- activity ----------------
    sd_act_timer #(.ACT_HOLD(ACT_HOLD)) u_act (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .mosi    (m_mosi),
        .miso    (m_miso),
        .act     (act)
    );

    assign led_vsd  = vsd_sel & act;
    assign led_phys = ~vsd_sel & act;

endmodule

// File: tb/tb_sd_spi_switch.sv
// tb_sd_spi_switch
//   Directed bench for sd_spi_switch with shortened ACT_HOLD. Each switch that
//   the stimulus requests pushes its expected busy length and final target to
//   a scoreboard queue; wait_switch pops and compares when the switch ends.
//   Builds with or without SD_SWITCH_FORCE_EN.
module tb_sd_spi_switch;

    localparam int GUARD   = 16;
    localparam int TIMEOUT = 100;
    localparam int HOLD    = 40;

    logic clk_sys = 1'b0;
    logic reset_n;
    logic img_mounted, img_present;
    logic m_sck, m_mosi, m_cs_n, m_miso;
    logic p_sck, p_mosi, p_cs_n, p_miso;
    logic v_sck, v_mosi, v_cs_n, v_miso;
    logic vsd_sel, busy, forced, led_vsd, led_phys;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   busy_len;
        logic sel;
    } exp_t;
    exp_t sb_q[$];

    sd_spi_switch #(
        .GUARD_CYCLES  (GUARD),
        .DRAIN_TIMEOUT (TIMEOUT),
        .ACT_HOLD      (HOLD)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .img_mounted (img_mounted),
        .img_present (img_present),
        .m_sck       (m_sck),
        .m_mosi      (m_mosi),
        .m_cs_n      (m_cs_n),
        .m_miso      (m_miso),
        .p_sck       (p_sck),
        .p_mosi      (p_mosi),
        .p_cs_n      (p_cs_n),
        .p_miso      (p_miso),
        .v_sck       (v_sck),
        .v_mosi      (v_mosi),
        .v_cs_n      (v_cs_n),
        .v_miso      (v_miso),
        .vsd_sel     (vsd_sel),
        .busy        (busy),
        .forced      (forced),
        .led_vsd     (led_vsd),
        .led_phys    (led_phys)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mount(input logic present);
        img_mounted = 1'b1;
        img_present = present;
        tick();
        img_mounted = 1'b0;
    endtask

    // Counts busy cycles until the switch finishes, then compares against the
    // oldest scoreboard entry. With toggle set, m_sck is wiggled during busy
    // cycles and neither card may see it (only valid when all busy cycles are
    // GUARD cycles).
    task automatic wait_switch(input string tag, input bit toggle);
        int   n = 0;
        bit   done = 0;
        bit   leak = 0;
        exp_t e;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (busy) begin
                n++;
                if (toggle) begin
                    m_sck = ~m_sck;
                    #1;
                    if (p_sck || v_sck) leak = 1;
                end
            end else if (n > 0) begin
                done = 1;
            end
        end
        m_sck = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_busy_len"}, 32'(n), 32'(e.busy_len));
            check({tag, "_vsd_sel"}, 32'(vsd_sel), 32'(e.sel));
        end
        if (toggle) check({tag, "_sck_isolated"}, 32'(leak), 32'd0);
    endtask

    initial begin
        int   n;
        bit   leak;
        exp_t e;

        reset_n = 1'b0;
        img_mounted = 1'b0; img_present = 1'b0;
        m_sck = 1'b0; m_mosi = 1'b0; m_cs_n = 1'b1;
        p_miso = 1'b0; v_miso = 1'b0;
        #1;
        check("rst_vsd_sel", 32'(vsd_sel), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_forced",  32'(forced),  32'd0);
        tick(); tick();
        reset_n = 1'b1;

        // ---- activity hold after reset: counter values 0..HOLD-1 ----
        n = 0;
        if (led_phys) n++;
        for (int i = 0; i < HOLD + 10; i++) begin
            tick();
            if (led_phys) n++;
            else break;
        end
        check("act_hold_cycles", 32'(n), 32'(HOLD));
        check("act_led_vsd_off", 32'(led_vsd), 32'd0);

        // ---- physical routing after reset ----
        m_cs_n = 1'b0; #1;
        check("phys_cs_follow",  32'(p_cs_n), 32'd0);
        check("virt_cs_idle",    32'(v_cs_n), 32'd1);
        m_sck = 1'b1; m_mosi = 1'b1; p_miso = 1'b1; #1;
        check("phys_route", 32'({p_sck, p_mosi, m_miso}), 32'b111);
        check("virt_idle",  32'({v_sck, v_mosi}),          32'b00);
        v_miso = 1'b1; p_miso = 1'b0; #1;
        check("miso_from_phys", 32'(m_miso), 32'd0);
        m_sck = 1'b0; m_mosi = 1'b0; m_cs_n = 1'b1; v_miso = 1'b0;
        tick();

        // ---- idle bus: switch to virtual, DRAIN 1 + GUARD 16 busy cycles ----
        mount(1'b1);
        e.busy_len = 1 + GUARD; e.sel = 1'b1; sb_q.push_back(e);
        wait_switch("sw_to_vsd", 1'b0);
        m_cs_n = 1'b0; m_sck = 1'b1; v_miso = 1'b1; #1;
        check("vsd_route",  32'({v_cs_n, v_sck, m_miso}), 32'b011);
        check("phys_isolated", 32'({p_cs_n, p_sck}), 32'b10);
        m_mosi = 1'b1;
        tick();
        check("led_vsd_active", 32'({led_vsd, led_phys}), 32'b10);
        m_sck = 1'b0; m_mosi = 1'b0; v_miso = 1'b0;

        // ---- mount during a transfer: old target kept until cs rises ----
        mount(1'b0);
        leak = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            m_sck = ~m_sck; #1;
            if (v_sck !== m_sck || p_sck !== 1'b0 || v_cs_n !== 1'b0) leak = 1;
        end
        check("drain_passthrough", 32'(leak), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        m_sck = 1'b0; m_cs_n = 1'b1;
        e.busy_len = GUARD; e.sel = 1'b0; sb_q.push_back(e);
        wait_switch("sw_after_cs", 1'b1);

        // ---- cs drops at guard_cnt=8: back to DRAIN, no switch ----
        mount(1'b1);
        tick(); tick();                       // DRAIN, then GUARD cnt 0
        repeat (8) tick();                    // guard_cnt = 8
        check("guard_isolated_miso", 32'({m_miso, p_cs_n}), 32'b11);
        m_cs_n = 1'b0; #1;
        check("guard_restore_cs",   32'(p_cs_n), 32'd0);
        check("guard_restore_miso", 32'(m_miso), 32'd0);
        tick();
        check("guard_back_drain", 32'({busy, vsd_sel}), 32'b10);
        repeat (3) tick();
        m_cs_n = 1'b1;
        e.busy_len = GUARD; e.sel = 1'b1; sb_q.push_back(e);
        wait_switch("sw_after_reguard", 1'b0);

        // ---- mount then re-mount of the original: abort ----
        m_cs_n = 1'b0;
        mount(1'b0);
        repeat (3) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        mount(1'b1);
        tick();
        check("abort_busy_after", 32'(busy),    32'd0);
        check("abort_vsd_sel",    32'(vsd_sel), 32'd1);
        m_cs_n = 1'b1;
        tick();

        // ---- mount coinciding with GUARD completion ----
        mount(1'b0);
        repeat (1 + GUARD) tick();            // DRAIN + GUARD cnt 0..15
        check("coinc_pre_busy", 32'(busy), 32'd1);
        mount(1'b1);
        check("coinc_old_req", 32'({vsd_sel, busy}), 32'b00);
        tick();
        check("coinc_new_req", 32'(busy), 32'd1);
        e.busy_len = GUARD; e.sel = 1'b1; sb_q.push_back(e);
        wait_switch("sw_coinc", 1'b0);

        // ---- master never deselects ----
        m_cs_n = 1'b0;
        mount(1'b0);
`ifdef SD_SWITCH_FORCE_EN
        e.busy_len = TIMEOUT + GUARD; e.sel = 1'b0; sb_q.push_back(e);
        wait_switch("sw_forced", 1'b0);
        check("forced_set", 32'(forced), 32'd1);
        m_cs_n = 1'b1;
        mount(1'b1);
        e.busy_len = 1 + GUARD; e.sel = 1'b1; sb_q.push_back(e);
        wait_switch("sw_unforced", 1'b0);
        check("forced_clear", 32'(forced), 32'd0);
`else
        repeat (TIMEOUT + GUARD + 40) tick();
        check("noforce_busy", 32'({busy, vsd_sel, forced}), 32'b110);
        m_cs_n = 1'b1;
        e.busy_len = GUARD; e.sel = 1'b0; sb_q.push_back(e);
        wait_switch("sw_late_cs", 1'b0);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
